tcb_arb_rr: RTL

TCB_ARB_RR -- requirements
Module: tcb_arb_rr

---
 rtl/tcb_arb_rr.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tcb_arb_rr.sv
// Arbiter that lets MAN_N TCB managers share one subordinate, with the response routed back after DLY cycles.
// Define TCB_ARB_RR_EN to get round-robin priority; otherwise the lowest-index manager wins.
module tcb_arb_rr #(
  parameter int unsigned MAN_N = 2,
  parameter int unsigned ADR   = 32,
  parameter int unsigned DAT   = 32,
  parameter int unsigned DLY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN_N-1:0]     sub_vld,
  input  logic [MAN_N-1:0]     sub_wen,
  input  logic [MAN_N*ADR-1:0] sub_adr,
  input  logic [MAN_N*3-1:0]   sub_fn3,
  input  logic [MAN_N*DAT-1:0] sub_wdt,
  output logic [MAN_N*DAT-1:0] sub_rdt,
  output logic [MAN_N-1:0]     sub_err,
  output logic [MAN_N-1:0]     sub_rdy,
  output logic                 man_vld,
  output logic                 man_wen,
  output logic [ADR-1:0]       man_adr,
  output logic [2:0]           man_fn3,
  output logic [DAT-1:0]       man_wdt,
  input  logic [DAT-1:0]       man_rdt,
  input  logic                 man_err,
  input  logic                 man_rdy
);

  localparam int unsigned IW = (MAN_N > 1) ? $clog2(MAN_N) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] sel;
  logic          selFound;
  logic [IW-1:0] grant;
  logic          xfer;

  logic          rspVld_q [DLY];
  logic [IW-1:0] rspIdx_q [DLY];

`ifdef TCB_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW:0]   rrIdx;

  // Scan managers starting at ptr_q, wrapping past the top index back to 0.
  always_comb begin
    sel      = '0;
    selFound = 1'b0;
    rrIdx    = '0;
    for (int k = 0; k < int'(MAN_N); k++) begin
      rrIdx = {1'b0, ptr_q} + (IW+1)'(k);
      if (rrIdx >= (IW+1)'(MAN_N)) rrIdx = rrIdx - (IW+1)'(MAN_N);
      if (!selFound && sub_vld[rrIdx[IW-1:0]]) begin
        sel      = rrIdx[IW-1:0];
        selFound = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel      = '0;
    selFound = 1'b0;
    for (int k = 0; k < int'(MAN_N); k++) begin
      if (!selFound && sub_vld[k]) begin
        sel      = IW'(k);
        selFound = 1'b1;
      end
    end
  end
`endif

  // A stalled request keeps its grant until it completes, whatever the others do.
  assign grant   = (state_q == HOLD) ? grant_q : sel;
  assign man_vld = sub_vld[grant];
  assign xfer    = man_vld & man_rdy;

  always_comb begin
    man_wen = 1'b0;
    man_adr = '0;
    man_fn3 = '0;
    man_wdt = '0;
    sub_rdy = '0;
    for (int i = 0; i < int'(MAN_N); i++) begin
      if (man_vld && grant == IW'(i)) begin
        man_wen    = sub_wen[i];
        man_adr    = sub_adr[i*ADR +: ADR];
        man_fn3    = sub_fn3[i*3 +: 3];
        man_wdt    = sub_wdt[i*DAT +: DAT];
        sub_rdy[i] = rst & man_rdy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (man_vld && !man_rdy) begin
            state_q <= HOLD;
            grant_q <= sel;
          end
        end
        HOLD: begin
          if (xfer) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TCB_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      if (grant == IW'(MAN_N - 1)) ptr_q <= '0;
      else                         ptr_q <= grant + 1'b1;
    end
  end
`endif

  // Each transfer's owner travels DLY stages so the response reaches the right manager.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < int'(DLY); s++) begin
        rspVld_q[s] <= 1'b0;
        rspIdx_q[s] <= '0;
      end
    end else begin
      rspVld_q[0] <= xfer;
      rspIdx_q[0] <= grant;
      for (int s = 1; s < int'(DLY); s++) begin
        rspVld_q[s] <= rspVld_q[s-1];
        rspIdx_q[s] <= rspIdx_q[s-1];
      end
    end
  end

  always_comb begin
    sub_rdt = '0;
    sub_err = '0;
    for (int i = 0; i < int'(MAN_N); i++) begin
      if (rspVld_q[DLY-1] && rspIdx_q[DLY-1] == IW'(i)) begin
        sub_rdt[i*DAT +: DAT] = man_rdt;
        sub_err[i]            = man_err;
      end
    end
  end

endmodule
